// File: rtl/line_engine.sv
// Pixel generator for a VGA-style frame buffer: draws Bresenham lines, filled
// rectangles and single pixels through a valid/ready pixel port.
module line_engine #(
   parameter int XW = 9,
   parameter int YW = 8,
   parameter int CW = 3
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic [1:0]    mode,
   input  logic [XW-1:0] x0,
   input  logic [YW-1:0] y0,
   input  logic [XW-1:0] x1,
   input  logic [YW-1:0] y1,
   input  logic [CW-1:0] colour_in,
   input  logic          pix_ready,
   output logic          busy,
   output logic          done,
   output logic          plot,
   output logic [XW-1:0] x_out,
   output logic [YW-1:0] y_out,
   output logic [CW-1:0] colour_out
);

   localparam int MW = (XW > YW) ? XW : YW;
   localparam int EW = MW + 2;

   localparam logic [1:0]           MODE_LINE = 2'b00;
   localparam logic [1:0]           MODE_RECT = 2'b01;
   localparam logic [XW-1:0]        X_ONE     = {{(XW-1){1'b0}}, 1'b1};
   localparam logic [YW-1:0]        Y_ONE     = {{(YW-1){1'b0}}, 1'b1};
   localparam logic signed [EW-1:0] E_ZERO    = {EW{1'b0}};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_DRAW   = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            mode_q, mode_d;
   logic [XW-1:0]         x0_q, x0_d, x1_q, x1_d;
   logic [YW-1:0]         y0_q, y0_d, y1_q, y1_d;
   logic [CW-1:0]         col_q, col_d;
   logic [XW-1:0]         dx_q, dx_d;
   logic [YW-1:0]         dy_q, dy_d;
   logic                  sx_q, sx_d, sy_q, sy_d;
   logic signed [EW-1:0]  err_q, err_d;
   logic [XW-1:0]         endx_q, endx_d, rowx_q, rowx_d;
   logic [YW-1:0]         endy_q, endy_d;
   logic [XW-1:0]         x_q, x_d;
   logic [YW-1:0]         y_q, y_d;
   logic [CW-1:0]         colour_q, colour_d;
   logic                  plot_q, plot_d, busy_q, busy_d, done_q, done_d;

   logic                  x_ge_s, y_ge_s;
   logic [XW-1:0]         adx_s, xmin_s, xmax_s;
   logic [YW-1:0]         ady_s, ymin_s, ymax_s;
   logic signed [EW-1:0]  sadx_s, sady_s, dxe_s, dye_s;
   logic signed [EW:0]    e2_s, dxw_s, dyw_s;
   logic                  step_x_s, step_y_s, last_s;

   assign x_ge_s = (x1_q >= x0_q);
   assign y_ge_s = (y1_q >= y0_q);
   assign adx_s  = x_ge_s ? (x1_q - x0_q) : (x0_q - x1_q);
   assign ady_s  = y_ge_s ? (y1_q - y0_q) : (y0_q - y1_q);
   assign xmin_s = x_ge_s ? x0_q : x1_q;
   assign xmax_s = x_ge_s ? x1_q : x0_q;
   assign ymin_s = y_ge_s ? y0_q : y1_q;
   assign ymax_s = y_ge_s ? y1_q : y0_q;
   assign sadx_s = signed'({{(EW-XW){1'b0}}, adx_s});
   assign sady_s = signed'({{(EW-YW){1'b0}}, ady_s});

   // err is widened by two bits so 2*err never overflows at full-scale coordinates
   assign dxe_s    = signed'({{(EW-XW){1'b0}}, dx_q});
   assign dye_s    = signed'({{(EW-YW){1'b0}}, dy_q});
   assign dxw_s    = signed'({{(EW+1-XW){1'b0}}, dx_q});
   assign dyw_s    = signed'({{(EW+1-YW){1'b0}}, dy_q});
   assign e2_s     = {err_q, 1'b0};
   assign step_x_s = (e2_s > -dyw_s);
   assign step_y_s = (e2_s < dxw_s);
   assign last_s   = (x_q == endx_q) && (y_q == endy_q);

   // Next-state and datapath update for the drawing FSM
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      x0_d     = x0_q;
      y0_d     = y0_q;
      x1_d     = x1_q;
      y1_d     = y1_q;
      col_d    = col_q;
      dx_d     = dx_q;
      dy_d     = dy_q;
      sx_d     = sx_q;
      sy_d     = sy_q;
      err_d    = err_q;
      endx_d   = endx_q;
      endy_d   = endy_q;
      rowx_d   = rowx_q;
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
      plot_d   = plot_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d  = mode;
               x0_d    = x0;
               y0_d    = y0;
               x1_d    = x1;
               y1_d    = y1;
               col_d   = colour_in;
               busy_d  = 1'b1;
               state_d = S_SETUP;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SETUP: begin
            dx_d     = adx_s;
            dy_d     = ady_s;
            sx_d     = ~x_ge_s;
            sy_d     = ~y_ge_s;
            err_d    = sadx_s - sady_s;
            colour_d = col_q;
            plot_d   = 1'b1;
            state_d  = S_DRAW;
            case (mode_q)
               MODE_LINE: begin
                  x_d    = x0_q;
                  y_d    = y0_q;
                  rowx_d = x0_q;
                  endx_d = x1_q;
                  endy_d = y1_q;
               end
               MODE_RECT: begin
                  x_d    = xmin_s;
                  y_d    = ymin_s;
                  rowx_d = xmin_s;
                  endx_d = xmax_s;
                  endy_d = ymax_s;
               end
               default: begin
                  x_d    = x0_q;
                  y_d    = y0_q;
                  rowx_d = x0_q;
                  endx_d = x0_q;
                  endy_d = y0_q;
               end
            endcase
         end
         S_DRAW: begin
            if (pix_ready) begin
               if (last_s) begin
                  plot_d  = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_FINISH;
               end else begin
                  case (mode_q)
                     MODE_LINE: begin
                        err_d = err_q - (step_x_s ? dye_s : E_ZERO)
                                      + (step_y_s ? dxe_s : E_ZERO);
                        if (step_x_s) begin
                           x_d = sx_q ? (x_q - X_ONE) : (x_q + X_ONE);
                        end else begin
                           x_d = x_q;
                        end
                        if (step_y_s) begin
                           y_d = sy_q ? (y_q - Y_ONE) : (y_q + Y_ONE);
                        end else begin
                           y_d = y_q;
                        end
                     end
                     MODE_RECT: begin
                        if (x_q == endx_q) begin
                           x_d = rowx_q;
                           y_d = y_q + Y_ONE;
                        end else begin
                           x_d = x_q + X_ONE;
                        end
                     end
                     default: begin
                        x_d = x_q;
                     end
                  endcase
               end
            end else begin
               state_d = S_DRAW;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously by reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         mode_q   <= 2'b00;
         x0_q     <= {XW{1'b0}};
         y0_q     <= {YW{1'b0}};
         x1_q     <= {XW{1'b0}};
         y1_q     <= {YW{1'b0}};
         col_q    <= {CW{1'b0}};
         dx_q     <= {XW{1'b0}};
         dy_q     <= {YW{1'b0}};
         sx_q     <= 1'b0;
         sy_q     <= 1'b0;
         err_q    <= E_ZERO;
         endx_q   <= {XW{1'b0}};
         endy_q   <= {YW{1'b0}};
         rowx_q   <= {XW{1'b0}};
         x_q      <= {XW{1'b0}};
         y_q      <= {YW{1'b0}};
         colour_q <= {CW{1'b0}};
         plot_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         x0_q     <= x0_d;
         y0_q     <= y0_d;
         x1_q     <= x1_d;
         y1_q     <= y1_d;
         col_q    <= col_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
         sx_q     <= sx_d;
         sy_q     <= sy_d;
         err_q    <= err_d;
         endx_q   <= endx_d;
         endy_q   <= endy_d;
         rowx_q   <= rowx_d;
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
         plot_q   <= plot_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign plot       = plot_q;
   assign x_out      = x_q;
   assign y_out      = y_q;
   assign colour_out = colour_q;

endmodule

// File: tb/tb_line_engine.sv
// Directed self-checking bench for line_engine: lines, rectangles, single pixels,
// backpressure, busy/finish start filtering and mid-primitive reset.
module tb_line_engine;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic [1:0] mode;
   logic [8:0] x0, x1;
   logic [7:0] y0, y1;
   logic [2:0] colour_in;
   logic       pix_ready;
   logic       busy, done, plot;
   logic [8:0] x_out;
   logic [7:0] y_out;
   logic [2:0] colour_out;

   int n_checks = 0;
   int n_errors = 0;

   int cap_x[64];
   int cap_y[64];
   int cap_c[64];
   int cap_n, done_cnt, first_k;

   int e38x[6] = '{0, 1, 2, 3, 4, 5};
   int e38y[6] = '{0, 0, 1, 1, 2, 2};
   int e39x[8] = '{3, 3, 2, 2, 2, 2, 1, 1};
   int e40x[6] = '{8, 9, 10, 8, 9, 10};
   int e40y[6] = '{20, 20, 20, 21, 21, 21};

   line_engine #(.XW(9), .YW(8), .CW(3)) dut (
      .clock(clock), .reset(reset), .start(start), .mode(mode),
      .x0(x0), .y0(y0), .x1(x1), .y1(y1), .colour_in(colour_in),
      .pix_ready(pix_ready), .busy(busy), .done(done), .plot(plot),
      .x_out(x_out), .y_out(y_out), .colour_out(colour_out)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Pulse start for one sampling edge, then scramble the inputs (don't-care afterwards)
   task automatic start_prim(input logic [1:0] m, input int ax, input int ay,
                             input int bx, input int by, input int c);
      mode = m; x0 = 9'(ax); y0 = 8'(ay); x1 = 9'(bx); y1 = 8'(by); colour_in = 3'(c);
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      mode = ~m; x0 = ~x0; y0 = ~y0; x1 = ~x1; y1 = ~y1; colour_in = ~colour_in;
      check_eq("busy_after_start", 32'(busy), 32'd1);
      check_eq("plot_in_setup", 32'(plot), 32'd0);
   endtask

   // Record consumed pixels under a repeating ready pattern until done (bounded)
   task automatic collect(input logic [3:0] rdy_pat);
      logic prev_stall;
      int   px, py, pc, pp, post;
      cap_n = 0; done_cnt = 0; first_k = -1;
      prev_stall = 1'b0; px = 0; py = 0; pc = 0; pp = 0; post = 0;
      for (int i = 0; i < 64; i++) begin
         cap_x[i] = 0; cap_y[i] = 0; cap_c[i] = 0;
      end
      for (int k = 1; k <= 200; k++) begin
         @(posedge clock); #1;
         if (prev_stall) begin
            check_eq("stall_x", 32'(x_out), px);
            check_eq("stall_y", 32'(y_out), py);
            check_eq("stall_c", 32'(colour_out), pc);
            check_eq("stall_plot", 32'(plot), pp);
         end
         if (done) begin
            done_cnt++;
            check_eq("done_busy", 32'(busy), 32'd0);
            check_eq("done_plot", 32'(plot), 32'd0);
         end
         if (plot && first_k < 0) first_k = k;
         pix_ready = rdy_pat[(k-1)%4];
         if (plot && pix_ready && cap_n < 64) begin
            cap_x[cap_n] = int'(x_out);
            cap_y[cap_n] = int'(y_out);
            cap_c[cap_n] = int'(colour_out);
            cap_n++;
         end
         prev_stall = plot && !pix_ready;
         px = int'(x_out); py = int'(y_out); pc = int'(colour_out); pp = int'(plot);
         if (done_cnt > 0) post++;
         if (post > 3) break;
      end
      pix_ready = 1'b1;
   endtask

   initial begin
      logic found;
      int   seen_plot, seen_done;
      reset = 1'b1; start = 1'b0; mode = 2'b00; x0 = 9'd0; y0 = 8'd0;
      x1 = 9'd0; y1 = 8'd0; colour_in = 3'd0; pix_ready = 1'b1;
      #12;
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_plot", 32'(plot), 32'd0);
      check_eq("rst_x", 32'(x_out), 32'd0);
      check_eq("rst_y", 32'(y_out), 32'd0);
      check_eq("rst_c", 32'(colour_out), 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      // Shallow line, started in the first cycle after reset
      start_prim(2'b00, 0, 0, 5, 2, 5);
      collect(4'b1111);
      check_eq("l38_count", cap_n, 6);
      check_eq("l38_first_plot", first_k, 1);
      check_eq("l38_done", done_cnt, 1);
      check_eq("l38_colour", cap_c[0], 5);
      for (int i = 0; i < 6; i++) begin
         check_eq("l38_x", cap_x[i], e38x[i]);
         check_eq("l38_y", cap_y[i], e38y[i]);
      end

      // Steep line drawn towards the origin
      start_prim(2'b00, 3, 7, 1, 0, 2);
      collect(4'b1111);
      check_eq("l39_count", cap_n, 8);
      check_eq("l39_done", done_cnt, 1);
      for (int i = 0; i < 8; i++) begin
         check_eq("l39_x", cap_x[i], e39x[i]);
         check_eq("l39_y", cap_y[i], 7 - i);
      end

      // Filled rectangle with swapped X corners
      start_prim(2'b01, 10, 20, 8, 21, 6);
      collect(4'b1111);
      check_eq("r40_count", cap_n, 6);
      check_eq("r40_done", done_cnt, 1);
      for (int i = 0; i < 6; i++) begin
         check_eq("r40_x", cap_x[i], e40x[i]);
         check_eq("r40_y", cap_y[i], e40y[i]);
      end

      // Backpressure with ready pattern 1,0,0,1
      start_prim(2'b00, 0, 0, 3, 0, 4);
      collect(4'b1001);
      check_eq("bp_count", cap_n, 4);
      check_eq("bp_done", done_cnt, 1);
      for (int i = 0; i < 4; i++) begin
         check_eq("bp_x", cap_x[i], i);
         check_eq("bp_y", cap_y[i], 0);
      end

      // Coincident endpoints, with a start attempted while busy and stalled
      start_prim(2'b00, 319, 239, 319, 239, 3);
      pix_ready = 1'b0;
      start = 1'b1; mode = 2'b01; x0 = 9'd0; y0 = 8'd0; x1 = 9'd5; y1 = 8'd5; colour_in = 3'd7;
      repeat (3) @(posedge clock);
      #1;
      start = 1'b0;
      check_eq("cc_hold_x", 32'(x_out), 32'd319);
      check_eq("cc_hold_y", 32'(y_out), 32'd239);
      check_eq("cc_hold_c", 32'(colour_out), 32'd3);
      collect(4'b1111);
      check_eq("cc_count", cap_n, 1);
      check_eq("cc_x", cap_x[0], 319);
      check_eq("cc_y", cap_y[0], 239);
      check_eq("cc_done", done_cnt, 1);

      // Single-pixel mode, then a start held across the finish cycle
      start_prim(2'b10, 7, 9, 100, 50, 1);
      @(posedge clock); #1;
      check_eq("px_plot", 32'(plot), 32'd1);
      check_eq("px_x", 32'(x_out), 32'd7);
      check_eq("px_y", 32'(y_out), 32'd9);
      @(posedge clock); #1;
      check_eq("px_done", 32'(done), 32'd1);
      check_eq("px_busy_fin", 32'(busy), 32'd0);
      start = 1'b1; mode = 2'b10; x0 = 9'd1; y0 = 8'd1; x1 = 9'd1; y1 = 8'd1;
      @(posedge clock); #1;
      check_eq("fin_start_ignored", 32'(busy), 32'd0);
      check_eq("fin_done_once", 32'(done), 32'd0);
      @(posedge clock); #1;
      start = 1'b0;
      check_eq("after_fin_accept", 32'(busy), 32'd1);
      collect(4'b1111);
      check_eq("af_count", cap_n, 1);
      check_eq("af_x", cap_x[0], 1);
      check_eq("af_y", cap_y[0], 1);

      // Full-scale diagonal line and rectangle at the far corner
      start_prim(2'b00, 509, 255, 511, 253, 7);
      collect(4'b1111);
      check_eq("fs_line_count", cap_n, 3);
      for (int i = 0; i < 3; i++) begin
         check_eq("fs_line_x", cap_x[i], 509 + i);
         check_eq("fs_line_y", cap_y[i], 255 - i);
      end
      start_prim(2'b01, 511, 255, 510, 254, 7);
      collect(4'b1111);
      check_eq("fs_rect_count", cap_n, 4);
      for (int i = 0; i < 4; i++) begin
         check_eq("fs_rect_x", cap_x[i], 510 + (i % 2));
         check_eq("fs_rect_y", cap_y[i], 254 + (i / 2));
      end

      // Reset on the third pixel of a ten-pixel line
      start_prim(2'b00, 0, 0, 9, 0, 5);
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clock); #1;
         if (plot && x_out == 9'd2) begin
            found = 1'b1;
            break;
         end
      end
      check_eq("rs_third_pixel_seen", 32'(found), 32'd1);
      #1 reset = 1'b1;
      #1;
      check_eq("rs_plot", 32'(plot), 32'd0);
      check_eq("rs_busy", 32'(busy), 32'd0);
      check_eq("rs_x", 32'(x_out), 32'd0);
      check_eq("rs_y", 32'(y_out), 32'd0);
      check_eq("rs_c", 32'(colour_out), 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      seen_plot = 0; seen_done = 0;
      repeat (5) begin
         @(posedge clock); #1;
         if (plot) seen_plot++;
         if (done) seen_done++;
      end
      check_eq("rs_no_plot", seen_plot, 0);
      check_eq("rs_no_done", seen_done, 0);
      start_prim(2'b00, 0, 0, 5, 2, 1);
      collect(4'b1111);
      check_eq("rs_redraw_count", cap_n, 6);
      check_eq("rs_redraw_end_x", cap_x[5], 5);
      check_eq("rs_redraw_end_y", cap_y[5], 2);
      check_eq("rs_redraw_done", done_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
